i2s_slave_transceiver: RTL and testbench
========================================

Name: i2s_slave_transceiver

Overview:
- Full-duplex I2S target (slave) interface: sclk and ws are driven by an external I2S master (codec or second board), not generated locally.
- Oversamples sclk/ws/sd_rx on mclk, deserialises left/right receive words, and serialises left/right transmit words.
- Sits beside i2s_sender/i2s_receiver in the audio I/O layer, for links where the FPGA is the clock follower.

Parameters:
- d_width, 24, audio sample width in bits; slot length per channel ≥ d_width (extra slot bits ignored on rx, zero on tx).
- sync_stages, 2, flip-flop stages in the input synchronisers for sclk, ws and sd_rx (≥2).

Ports:
- mclk  input  1  system clock; all logic on rising edge; must be ≥8× external sclk.
- reset  input  1  synchronous, active-high reset.
- sclk  input  1  external bit clock (asynchronous to mclk).
- ws  input  1  external word select; 0 = left, 1 = right.
- sd_rx  input  1  serial data in, MSB first.
- sd_tx  output  1  serial data out, MSB first.
- l_data_tx  input  d_width  left sample to transmit (signed).
- r_data_tx  input  d_width  right sample to transmit (signed).
- tx_load  output  1  one-mclk pulse when l_data_tx/r_data_tx are captured.
- l_data_rx  output  d_width  last complete left sample received.
- r_data_rx  output  d_width  last complete right sample received.
- rx_valid  output  1  one-mclk pulse when a left/right pair has been updated.
- frame_err  output  1  one-mclk pulse on a short word (fewer than d_width bits).
- synced  output  1  high once the first ws transition has been seen.

Behaviour:
- Reset (sampled on mclk edge): all outputs 0, shift registers, bit counters, holding registers and synchroniser/edge registers cleared; synced = 0.
- sclk, ws and sd_rx each pass through a sync_stages-deep synchroniser, then a 1-flop edge detector. An sclk rise or fall event is a single mclk cycle.
- On each sclk rise event: sample ws_s and sd_rx_s.
  - If rx bit count < d_width: shift the bit in (left shift) and increment the count.
  - Then compare ws_s with ws_prev. If they differ (word boundary), the word just finished belongs to channel ws_prev.
- Word boundary, receive:
  - Not synced: discard the word, set synced = 1.
  - Synced, count == d_width: write the shift register to l_data_rx (ws_prev = 0) or r_data_rx (ws_prev = 1).
  - Synced, count < d_width: no output update; frame_err pulses in the next mclk cycle.
  - Completion of a right word (ws_prev = 1, valid) pulses rx_valid in the next mclk cycle, only if the preceding left word was also valid. Otherwise no rx_valid.
  - Count and shift register cleared; ws_prev ← ws_s. The bit sampled at the boundary rise is the previous word's LSB; the next rise samples the new MSB (standard I2S one-bit delay).
- Word boundary, transmit:
  - New ws_s = 0: capture l_data_tx and r_data_tx into holding registers and pulse tx_load in the same mclk cycle. Load the tx shift register with the captured left value.
  - New ws_s = 1: load the tx shift register with the held right value.
  - Before the first boundary after reset the tx shift register holds 0.
- On each sclk fall event: sd_tx ← tx shift MSB, shift left with zero fill. After d_width bits, sd_tx stays 0 until the next load.
- Both edge events in the same cycle is impossible by construction; no special handling.
- Edge-event to sd_tx latency = sync_stages + 2 mclk. This is why mclk ≥ 8× sclk is required.
- Reset mid-frame: synced drops to 0 and the partial frame is discarded. Resynchronisation happens at the next ws transition. No frame_err is raised for the first partial word.
- Slot longer than d_width (e.g. 32-bit slots, d_width 24): extra rx bits ignored, tx pads zeros; no error.

Test Plan:
- Bench master: sclk = mclk/8, 32 sclk per channel, sends L=24'h123456, R=24'hABCDEF after one sync frame → l_data_rx=24'h123456, r_data_rx=24'hABCDEF, one rx_valid per frame, frame_err never asserted.
- l_data_tx=24'h800001, r_data_tx=24'h7FFFFE held constant → bench slave-side decoder reads exactly those values each frame; sd_tx=0 in slot bits 24–31; tx_load pulses once per frame at the ws fall.
- Master sends a 20-bit right slot (ws toggles early) → frame_err pulses once, r_data_rx keeps previous value, no rx_valid that frame; next full frame restores rx_valid.
- Reset asserted mid left word for 3 mclk → all outputs 0, synced=0. The first ws transition sets synced with no frame_err; the first full frame after that yields correct data and rx_valid.
- Change l_data_tx from 24'h000001 to 24'hFFFFFF while the right word is being sent → the current frame still transmits the old left value; the new value appears from the next ws fall.
- Stretched sclk (mclk/16) with jittered ws phase ±1 mclk → identical data results to the mclk/8 case.

Source files
------------

// File: rtl/i2s_slave_transceiver.sv
// Full-duplex I2S target: sclk/ws come from an external master and are oversampled on mclk.
// Receives left/right words MSB first with the standard one-bit delay and transmits held samples.
module i2s_slave_transceiver #(
  parameter int d_width     = 24,
  parameter int sync_stages = 2
) (
  input  logic               mclk,
  input  logic               reset,
  input  logic               sclk,
  input  logic               ws,
  input  logic               sd_rx,
  output logic               sd_tx,
  input  logic [d_width-1:0] l_data_tx,
  input  logic [d_width-1:0] r_data_tx,
  output logic               tx_load,
  output logic [d_width-1:0] l_data_rx,
  output logic [d_width-1:0] r_data_rx,
  output logic               rx_valid,
  output logic               frame_err,
  output logic               synced
);

  localparam int CW = $clog2(d_width + 1);

  logic [sync_stages-1:0] r_sclk_sync;
  logic [sync_stages-1:0] r_ws_sync;
  logic [sync_stages-1:0] r_sd_sync;
  logic                   r_sclk_d;

  logic [d_width-1:0] r_rx_shift;
  logic [CW-1:0]      r_rx_cnt;
  logic               r_ws_prev;
  logic               r_synced;
  logic               r_left_ok;
  logic [d_width-1:0] r_l_data;
  logic [d_width-1:0] r_r_data;
  logic               r_rx_valid;
  logic               r_frame_err;

  logic [d_width-1:0] r_tx_shift;
  logic [d_width-1:0] r_r_hold;
  logic               r_sd_tx;

  logic               w_sclk_s;
  logic               w_ws_s;
  logic               w_sd_s;
  logic               w_rise;
  logic               w_fall;
  logic               w_bit_ok;
  logic [d_width-1:0] w_rx_shift_nxt;
  logic [CW-1:0]      w_rx_cnt_nxt;
  logic               w_boundary;
  logic               w_word_full;
  logic               w_tx_cap;

  // All three inputs share the same depth so ws/sd stay aligned with the sclk edge event.
  always_ff @(posedge mclk) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_ws_sync   <= '0;
      r_sd_sync   <= '0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[sync_stages-2:0], sclk};
      r_ws_sync   <= {r_ws_sync[sync_stages-2:0], ws};
      r_sd_sync   <= {r_sd_sync[sync_stages-2:0], sd_rx};
      r_sclk_d    <= w_sclk_s;
    end
  end

  assign w_sclk_s       = r_sclk_sync[sync_stages-1];
  assign w_ws_s         = r_ws_sync[sync_stages-1];
  assign w_sd_s         = r_sd_sync[sync_stages-1];
  assign w_rise         = w_sclk_s & ~r_sclk_d;
  assign w_fall         = ~w_sclk_s & r_sclk_d;
  assign w_bit_ok       = (r_rx_cnt < CW'(d_width));
  assign w_rx_shift_nxt = w_bit_ok ? {r_rx_shift[d_width-2:0], w_sd_s} : r_rx_shift;
  assign w_rx_cnt_nxt   = w_bit_ok ? (r_rx_cnt + CW'(1)) : r_rx_cnt;
  assign w_boundary     = w_rise & (w_ws_s != r_ws_prev);
  assign w_word_full    = (w_rx_cnt_nxt == CW'(d_width));
  assign w_tx_cap       = w_boundary & ~w_ws_s;

  // The bit sampled on the boundary rise is still the LSB of the word that just ended.
  always_ff @(posedge mclk) begin
    if (reset) begin
      r_rx_shift  <= '0;
      r_rx_cnt    <= '0;
      r_ws_prev   <= 1'b0;
      r_synced    <= 1'b0;
      r_left_ok   <= 1'b0;
      r_l_data    <= '0;
      r_r_data    <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_boundary) begin
        r_rx_shift <= '0;
        r_rx_cnt   <= '0;
        r_ws_prev  <= w_ws_s;
        if (!r_synced) begin
          r_synced  <= 1'b1;
          r_left_ok <= 1'b0;
        end else if (w_word_full) begin
          if (r_ws_prev) begin
            r_r_data   <= w_rx_shift_nxt;
            r_rx_valid <= r_left_ok;
            r_left_ok  <= 1'b0;
          end else begin
            r_l_data  <= w_rx_shift_nxt;
            r_left_ok <= 1'b1;
          end
        end else begin
          r_frame_err <= 1'b1;
          r_left_ok   <= 1'b0;
        end
      end else if (w_rise) begin
        r_rx_shift <= w_rx_shift_nxt;
        r_rx_cnt   <= w_rx_cnt_nxt;
      end
    end
  end

  // Both samples are captured at the ws fall so a frame always carries a matched pair.
  always_ff @(posedge mclk) begin
    if (reset) begin
      r_tx_shift <= '0;
      r_r_hold   <= '0;
      r_sd_tx    <= 1'b0;
    end else begin
      if (w_boundary) begin
        if (w_ws_s) begin
          r_tx_shift <= r_r_hold;
        end else begin
          r_r_hold   <= r_data_tx;
          r_tx_shift <= l_data_tx;
        end
      end else if (w_fall) begin
        r_sd_tx    <= r_tx_shift[d_width-1];
        r_tx_shift <= {r_tx_shift[d_width-2:0], 1'b0};
      end
    end
  end

  // Pulse semantics: tx_load is high in the cycle whose closing edge captures l/r_data_tx;
  // rx_valid and frame_err are single-cycle strobes with no back-pressure.
  assign tx_load   = w_tx_cap & ~reset;
  assign sd_tx     = r_sd_tx;
  assign l_data_rx = r_l_data;
  assign r_data_rx = r_r_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign synced    = r_synced;

endmodule

// File: tb/tb_i2s_slave_transceiver.sv
// Bench for i2s_slave_transceiver: an I2S master model drives sclk/ws/sd_rx and decodes sd_tx,
// with rx and tx words checked against expectation queues.
module tb_i2s_slave_transceiver;

  localparam int W = 24;

  logic         mclk = 1'b0;
  logic         reset = 1'b1;
  logic         sclk = 1'b0;
  logic         ws = 1'b0;
  logic         sd_rx = 1'b0;
  logic         sd_tx;
  logic [W-1:0] l_data_tx = '0;
  logic [W-1:0] r_data_tx = '0;
  logic         tx_load;
  logic [W-1:0] l_data_rx;
  logic [W-1:0] r_data_rx;
  logic         rx_valid;
  logic         frame_err;
  logic         synced;

  i2s_slave_transceiver #(.d_width(W), .sync_stages(2)) dut (
    .mclk      (mclk),
    .reset     (reset),
    .sclk      (sclk),
    .ws        (ws),
    .sd_rx     (sd_rx),
    .sd_tx     (sd_tx),
    .l_data_tx (l_data_tx),
    .r_data_tx (r_data_tx),
    .tx_load   (tx_load),
    .l_data_rx (l_data_rx),
    .r_data_rx (r_data_rx),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .synced    (synced)
  );

  // ---------------- clock / reset ----------------
  always #5 mclk = ~mclk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int           n_checks = 0;
  int           n_fail = 0;
  int           err_cnt = 0;
  int           load_cnt = 0;
  int           n_frames = 0;
  int           half = 4;
  logic [W-1:0] exp_rx_q[$];
  logic [W-1:0] exp_tx_q[$];
  logic [W-1:0] model_r = '0;
  logic [W-1:0] tx_word = '0;
  logic [W-1:0] el;
  logic [W-1:0] er;
  logic         rst_req = 1'b0;
  logic         p_valid = 1'b0;
  logic         p_sd = 1'b0;
  logic         p_chk = 1'b0;
  int           p_k = 0;
  logic         l_valid = 1'b0;
  logic         l_chk = 1'b0;
  int           l_k = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_l_data_rx", 32'(l_data_rx), 0);
    check_eq("rst_r_data_rx", 32'(r_data_rx), 0);
    check_eq("rst_rx_valid", 32'(rx_valid), 0);
    check_eq("rst_frame_err", 32'(frame_err), 0);
    check_eq("rst_synced", 32'(synced), 0);
    check_eq("rst_sd_tx", 32'(sd_tx), 0);
    check_eq("rst_tx_load", 32'(tx_load), 0);
  endtask

  function automatic logic [W-1:0] rnd();
    return W'($urandom());
  endfunction

  // ---------------- output monitor ----------------
  always @(negedge mclk) begin
    if (!reset) begin
      if (rx_valid) begin
        if (exp_rx_q.size() < 2) begin
          check_eq("rx_valid_unexpected", 1, 0);
        end else begin
          el = exp_rx_q.pop_front();
          er = exp_rx_q.pop_front();
          check_eq("l_data_rx", 32'(l_data_rx), 32'(el));
          check_eq("r_data_rx", 32'(r_data_rx), 32'(er));
          model_r = er;
        end
      end
      if (frame_err) begin
        err_cnt++;
        check_eq("err_r_hold", 32'(r_data_rx), 32'(model_r));
      end
      if (tx_load) load_cnt++;
    end
  end

  // ---------------- master driver ----------------
  // One sclk period; tx_bit is the slave output left by the previous fall.
  task automatic drive_period(input logic ws_v, input logic sd_v, output logic tx_bit);
    int jit;
    @(negedge mclk);
    tx_bit = sd_tx;
    if (rst_req) begin
      rst_req = 1'b0;
      reset   = 1'b1;
      repeat (3) @(negedge mclk);
      check_reset_outputs();
      reset = 1'b0;
    end
    jit = (half > 4) ? int'($urandom_range(0, 2)) : 1;
    if (jit == 0) begin
      ws = ws_v;
      @(negedge mclk);
    end
    sclk  = 1'b0;
    sd_rx = sd_v;
    if (jit == 2) @(negedge mclk);
    ws = ws_v;
    repeat (half - ((jit == 2) ? 1 : 0)) @(negedge mclk);
    sclk = 1'b1;
    repeat (half - 1 - ((jit == 0) ? 1 : 0)) @(negedge mclk);
  endtask

  task automatic decode_tx(input logic b, input int k, input logic chk);
    logic [W-1:0] e;
    if (k < W) tx_word = {tx_word[W-2:0], b};
    if (chk) begin
      if (k == W - 1) begin
        if (exp_tx_q.size() == 0) begin
          check_eq("tx_queue_empty", 1, 0);
        end else begin
          e = exp_tx_q.pop_front();
          check_eq("tx_word", 32'(tx_word), 32'(e));
        end
      end else if (k >= W) begin
        check_eq("tx_pad", 32'(b), 0);
      end
    end
  endtask

  // ws of a period is the channel of the period after it (one-bit delay), hence the lookahead.
  task automatic add_period(input logic ch, input int k, input logic sd_v, input logic chk);
    logic b;
    if (p_valid) begin
      drive_period(ch, p_sd, b);
      if (l_valid) decode_tx(b, l_k, l_chk);
      l_valid = 1'b1;
      l_k     = p_k;
      l_chk   = p_chk;
    end
    p_valid = 1'b1;
    p_sd    = sd_v;
    p_k     = k;
    p_chk   = chk;
  endtask

  task automatic send_frame(input logic [W-1:0] lv, input logic [W-1:0] rv, input int nl,
                            input int nr, input bit rx_push, input bit tx_chk, input int rst_at,
                            input logic [W-1:0] new_l);
    n_frames++;
    if (rx_push) begin
      exp_rx_q.push_back(lv);
      exp_rx_q.push_back(rv);
    end
    if (tx_chk) begin
      exp_tx_q.push_back(l_data_tx);
      exp_tx_q.push_back(r_data_tx);
    end
    for (int k = 0; k < nl; k++) begin
      if (k == rst_at) rst_req = 1'b1;
      add_period(1'b0, k, (k < W) ? lv[W-1-k] : 1'b0, tx_chk);
    end
    for (int k = 0; k < nr; k++) begin
      if (k == 1) l_data_tx = new_l;
      add_period(1'b1, k, (k < W) ? rv[W-1-k] : 1'b0, tx_chk);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (4) @(negedge mclk);
    check_reset_outputs();
    reset = 1'b0;
    l_data_tx = 24'h800001;
    r_data_tx = 24'h7FFFFE;
    repeat (4) @(negedge mclk);

    // Sync frame, then full frames at mclk/8.
    send_frame(rnd(), rnd(), 32, 32, 1'b0, 1'b0, -1, 24'h800001);
    check_eq("synced_after_first_ws", 32'(synced), 1);
    send_frame(24'h123456, 24'hABCDEF, 32, 32, 1'b1, 1'b1, -1, 24'h800001);
    send_frame(rnd(), rnd(), 32, 32, 1'b1, 1'b1, -1, 24'h800001);
    send_frame(rnd(), rnd(), 32, 32, 1'b1, 1'b1, -1, 24'h800001);
    check_eq("err_cnt_clean", err_cnt, 0);
    check_eq("tx_load_cnt_a", load_cnt, n_frames - 1);

    // Short right slot, then a full frame.
    send_frame(rnd(), rnd(), 32, 20, 1'b0, 1'b0, -1, 24'h800001);
    send_frame(rnd(), rnd(), 32, 32, 1'b1, 1'b1, -1, 24'h800001);
    check_eq("err_cnt_short", err_cnt, 1);
    check_eq("tx_load_cnt_b", load_cnt, n_frames - 1);

    // Reset in the middle of a left word, then a full frame.
    send_frame(rnd(), rnd(), 32, 32, 1'b0, 1'b0, 10, 24'h800001);
    check_eq("synced_after_reset", 32'(synced), 1);
    check_eq("err_cnt_reset", err_cnt, 1);
    send_frame(rnd(), rnd(), 32, 32, 1'b1, 1'b1, -1, 24'h800001);
    check_eq("tx_load_cnt_c", load_cnt, n_frames - 1);

    // l_data_tx changes while the right word is sent.
    send_frame(rnd(), rnd(), 32, 32, 1'b1, 1'b1, -1, 24'h000001);
    send_frame(rnd(), rnd(), 32, 32, 1'b1, 1'b1, -1, 24'hFFFFFF);
    send_frame(rnd(), rnd(), 32, 32, 1'b1, 1'b1, -1, 24'hFFFFFF);
    check_eq("tx_load_cnt_d", load_cnt, n_frames - 1);

    // Stretched sclk (mclk/16) with ws jitter.
    half = 8;
    send_frame(24'h123456, 24'hABCDEF, 32, 32, 1'b1, 1'b1, -1, 24'hFFFFFF);
    send_frame(rnd(), rnd(), 32, 32, 1'b1, 1'b1, -1, 24'hFFFFFF);
    send_frame(rnd(), rnd(), 32, 32, 1'b1, 1'b1, -1, 24'hFFFFFF);

    for (int k = 0; k < 6; k++) add_period(1'b0, k, 1'b0, 1'b0);
    repeat (20) @(negedge mclk);

    check_eq("err_cnt_final", err_cnt, 1);
    check_eq("tx_load_cnt_final", load_cnt, n_frames);
    check_eq("rx_queue_drained", exp_rx_q.size(), 0);
    check_eq("tx_queue_drained", exp_tx_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
